shared_acc_arbiter: RTL and testbench
=====================================

Name: shared_acc_arbiter

Overview:
Shares one accelerator (the shared MUL/DIV unit) between NrCores requesting cores. Requests arrive as acc_req_t over valid/ready and are arbitrated round-robin onto a single accelerator request port. The requester index of every accepted request is recorded in an in-order tag FIFO, and each in-order acc_resp_t is routed back to the core that issued it.

Parameters:
NrCores, 4, number of requesting cores (2..16)
MaxOutstanding, 4, max requests in flight at the accelerator (power of 2, 1..16)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
core_qvalid_i  in  NrCores  per-core request valid
core_qready_o  out  NrCores  per-core request ready
core_qdata_i  in  NrCores x $bits(acc_req_t)  per-core request payload
core_pvalid_o  out  NrCores  per-core response valid
core_pready_i  in  NrCores  per-core response ready
core_pdata_o  out  $bits(acc_resp_t)  response payload, broadcast to all cores
acc_qvalid_o  out  1  accelerator request valid
acc_qready_i  in  1  accelerator request ready
acc_qdata_o  out  $bits(acc_req_t)  selected request
acc_pvalid_i  in  1  accelerator response valid
acc_pready_o  out  1  accelerator response ready
acc_pdata_i  in  $bits(acc_resp_t)  accelerator response
contention_cnt_o  out  32  cycles with more than one core_qvalid_i high (see Optional Feature)

Behaviour:
- Reset (async, rst_i=1): RR pointer=0, tag FIFO empty, outstanding count=0, contention counter=0. Outputs in reset: all core_qready_o=0, core_pvalid_o=0, acc_qvalid_o=0, acc_pready_o=0, core_pdata_o=0 if the tag FIFO is empty, contention_cnt_o=0.
- Request path is combinational (0-cycle latency). Winner = first requester with core_qvalid_i set, searched cyclically starting at the RR pointer.
- acc_qvalid_o = any core_qvalid_i AND count < MaxOutstanding. acc_qdata_o = winner payload, unmodified.
- core_qready_o[w] = acc_qready_i AND count < MaxOutstanding, only for the winner w. It is 0 for all other cores.
- On request handshake: push w into the tag FIFO, count++, RR pointer <= (w+1) mod NrCores. Without a handshake the pointer holds. A waiting requester is therefore served within NrCores grants.
- acc_qvalid_o may drop when the winner drops valid. The arbiter does not enforce core stability; cores hold valid until ready.
- The accelerator returns responses in request order. Head = tag FIFO head.
- core_pvalid_o[head] = acc_pvalid_i AND FIFO non-empty. Other cores see 0. core_pdata_o = acc_pdata_i.
- acc_pready_o = core_pready_i[head] AND FIFO non-empty. On response handshake: pop, count--.
- Response with FIFO empty: acc_pready_o=0. This is a protocol error and triggers an assertion.
- Push and pop in the same cycle: count unchanged, FIFO read/write both performed. When full, the same-cycle pop does not free space for a push, so request readiness never depends on response signals.
- count wraps neither way. Assertions: no push when full, no pop when empty.
- Reset mid-operation: all tags are dropped. Responses already in flight are the reset domain's responsibility; the accelerator is reset on the same rst_i.
- acc_resp_t.id passes through untouched. Routing uses only the tag FIFO.

Optional Feature:
SHARED_ACC_CONTENTION_CNT_EN
- Defined: 32-bit counter increments every cycle in which popcount(core_qvalid_i) >= 2. It saturates at 32'hFFFF_FFFF and clears only on reset. contention_cnt_o shows the counter.
- Undefined: no counter flops; contention_cnt_o tied to 0.

Decomposition:
- snitch_pkg: reuse acc_req_t, acc_resp_t, and the SHARED_MULDIV address.
- New package constant in snitch_pkg: SharedAccMaxOutstanding = 4.
- One sub-module: shared_acc_tag_fifo. Depth MaxOutstanding, width $clog2(NrCores). Provides full/empty/usage, no fall-through.
- The RR arbiter is inline logic.

Test Plan:
- Single core 2, acc always ready, accelerator responds 1 cycle later with data 0x1234 -> acc_qdata_o equals core 2 payload; core_pvalid_o=0b0100 with core_pdata_o.data=0x1234.
- All 4 cores valid continuously, pointer at 0 -> grants in order 0,1,2,3,0. Each core receives its own response in that order.
- acc_pvalid_i held 0 with 4 cores issuing -> exactly 4 handshakes, then all core_qready_o=0. The first response pop re-enables a grant the following cycle.
- Head core 1 holds core_pready_i=0 for 3 cycles while acc_pvalid_i=1 -> acc_pready_o=0 for those 3 cycles, no pop. Data and valid are stable.
- rst_i asserted asynchronously with 3 outstanding -> outputs go to reset values immediately; after release, count=0 and the RR pointer restarts at 0.
- Macro defined, cores 0 and 3 valid for 10 cycles, core 0 alone for 5 cycles -> contention_cnt_o=10. Macro undefined -> contention_cnt_o stays 0.

Source files
------------

// File: rtl/snitch_pkg.sv
// Shared accelerator interface types and the shared MUL/DIV arbitration defaults.
package snitch_pkg;

    typedef enum logic [31:0] {
        FP_SS         = 32'd0,
        SHARED_MULDIV = 32'd1
    } acc_addr_e;

    localparam int unsigned SharedAccMaxOutstanding = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  id;
        logic [31:0] data_op;
        logic [63:0] data_arga;
        logic [63:0] data_argb;
        logic [63:0] data_argc;
    } acc_req_t;

    typedef struct packed {
        logic [4:0]  id;
        logic        error;
        logic [63:0] data;
    } acc_resp_t;

endpackage

// File: rtl/shared_acc_tag_fifo.sv
// In-order requester-tag FIFO for the shared accelerator arbiter (no fall-through).
module shared_acc_tag_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 2
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic [Width-1:0]               data_i,
    input  logic                           pop_i,
    output logic [Width-1:0]               data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(Depth+1)-1:0]     usage_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr;
    logic [PtrW-1:0]  rd_ptr;
    logic [CntW-1:0]  cnt;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_i) wr_ptr <= ptr_inc(wr_ptr);
            if (pop_i)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push_i, pop_i})
                2'b10:   cnt <= cnt + CntW'(1);
                2'b01:   cnt <= cnt - CntW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem[wr_ptr] <= data_i;
    end

    assign data_o  = mem[rd_ptr];
    assign full_o  = (cnt == CntW'(Depth));
    assign empty_o = (cnt == '0);
    assign usage_o = cnt;

    push_when_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_i && full_o));
    pop_when_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(pop_i && empty_o));

endmodule

// File: rtl/shared_acc_arbiter.sv
// Round-robin sharing of one accelerator between NrCores cores with in-order response routing.
// Optional cycle-contention counter: define SHARED_ACC_CONTENTION_CNT_EN.
module shared_acc_arbiter
    import snitch_pkg::*;
#(
    parameter int unsigned NrCores        = 4,
    parameter int unsigned MaxOutstanding = SharedAccMaxOutstanding
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NrCores-1:0]       core_qvalid_i,
    output logic [NrCores-1:0]       core_qready_o,
    input  acc_req_t [NrCores-1:0]   core_qdata_i,
    output logic [NrCores-1:0]       core_pvalid_o,
    input  logic [NrCores-1:0]       core_pready_i,
    output acc_resp_t                core_pdata_o,
    output logic                     acc_qvalid_o,
    input  logic                     acc_qready_i,
    output acc_req_t                 acc_qdata_o,
    input  logic                     acc_pvalid_i,
    output logic                     acc_pready_o,
    input  acc_resp_t                acc_pdata_i,
    output logic [31:0]              contention_cnt_o
);
    localparam int unsigned IdxW = (NrCores > 1) ? $clog2(NrCores) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

    logic [IdxW-1:0] rr_ptr;
    logic [IdxW-1:0] winner;
    logic [IdxW-1:0] cand;
    logic [IdxW-1:0] tag_head;
    logic            found;
    logic            can_issue;
    logic            q_hs;
    logic            p_hs;
    logic            tag_full;
    logic            tag_empty;
    logic [CntW-1:0] tag_usage;

    // Cyclic search starting at the RR pointer; first valid requester wins.
    always_comb begin
        winner = rr_ptr;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned i = 0; i < NrCores; i++) begin
            cand = IdxW'((32'(rr_ptr) + i) % NrCores);
            if (!found && core_qvalid_i[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr <= '0;
        end else if (q_hs) begin
            rr_ptr <= (winner == IdxW'(NrCores - 1)) ? '0 : winner + IdxW'(1);
        end
    end

    // Readiness looks only at the FIFO occupancy, never at the response side.
    assign can_issue    = !rst_i && (32'(tag_usage) < MaxOutstanding);
    assign acc_qvalid_o = (|core_qvalid_i) && can_issue;
    assign acc_qdata_o  = core_qdata_i[winner];
    assign q_hs         = acc_qvalid_o && acc_qready_i;

    always_comb begin
        core_qready_o = '0;
        if (found && acc_qready_i && can_issue) core_qready_o[winner] = 1'b1;
    end

    always_comb begin
        core_pvalid_o = '0;
        if (acc_pvalid_i && !tag_empty) core_pvalid_o[tag_head] = 1'b1;
    end

    assign acc_pready_o = !tag_empty && core_pready_i[tag_head];
    assign p_hs         = acc_pvalid_i && acc_pready_o;
    assign core_pdata_o = tag_empty ? '0 : acc_pdata_i;

    shared_acc_tag_fifo #(
        .Depth (MaxOutstanding),
        .Width (IdxW)
    ) i_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (q_hs),
        .data_i  (winner),
        .pop_i   (p_hs),
        .data_o  (tag_head),
        .full_o  (tag_full),
        .empty_o (tag_empty),
        .usage_o (tag_usage)
    );

    resp_without_tag: assert property (@(posedge clk_i) disable iff (rst_i) acc_pvalid_i |-> !tag_empty);
    grant_when_full:  assert property (@(posedge clk_i) disable iff (rst_i) q_hs |-> !tag_full);

`ifdef SHARED_ACC_CONTENTION_CNT_EN
    logic [31:0] contention_q;
    logic        multi_valid;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi_valid = |(core_qvalid_i & (core_qvalid_i - NrCores'(1)));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            contention_q <= '0;
        end else if (multi_valid && (contention_q != '1)) begin
            contention_q <= contention_q + 32'd1;
        end
    end

    assign contention_cnt_o = contention_q;
`else
    assign contention_cnt_o = '0;
`endif

endmodule

// File: tb/tb_shared_acc_arbiter.sv
// Self-checking bench for shared_acc_arbiter against a queue-based reference of the sharing rules.
module tb_shared_acc_arbiter;
    import snitch_pkg::*;

    localparam int N   = 4;
    localparam int MAX = 4;

    typedef struct {
        int        core;
        acc_resp_t resp;
    } inflight_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    qv  = '0;
    logic [N-1:0]    pr  = '0;
    logic            aqr = 1'b0;
    logic            apv = 1'b0;
    acc_req_t [N-1:0] qdata;
    acc_resp_t       apdata;

    logic [N-1:0]    qready;
    logic [N-1:0]    pvalid;
    acc_resp_t       pdata;
    logic            aqv;
    logic            apr;
    acc_req_t        aqd;
    logic [31:0]     ccnt;

    int          total = 0;
    int          bad   = 0;
    inflight_t   q[$];
    int          rr;
    logic [31:0] cnt_model;
    int          hs_seen;
    int          hs_cnt;
    int          order[5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    shared_acc_arbiter #(
        .NrCores        (N),
        .MaxOutstanding (MAX)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .core_qvalid_i    (qv),
        .core_qready_o    (qready),
        .core_qdata_i     (qdata),
        .core_pvalid_o    (pvalid),
        .core_pready_i    (pr),
        .core_pdata_o     (pdata),
        .acc_qvalid_o     (aqv),
        .acc_qready_i     (aqr),
        .acc_qdata_o      (aqd),
        .acc_pvalid_i     (apv),
        .acc_pready_o     (apr),
        .acc_pdata_i      (apdata),
        .contention_cnt_o (ccnt)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic acc_req_t rand_req();
        acc_req_t r;
        r.addr      = SHARED_MULDIV;
        r.id        = 5'($urandom);
        r.data_op   = $urandom;
        r.data_arga = {$urandom, $urandom};
        r.data_argb = {$urandom, $urandom};
        r.data_argc = {$urandom, $urandom};
        return r;
    endfunction

    function automatic int model_winner(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [31:0] exp_contention();
`ifdef SHARED_ACC_CONTENTION_CNT_EN
        return cnt_model;
`else
        return 32'd0;
`endif
    endfunction

    task automatic drive(input logic [N-1:0] v, input logic aq, input logic ap, input logic [N-1:0] p);
        for (int c = 0; c < N; c++) qdata[c] = rand_req();
        qv     = v;
        aqr    = aq;
        pr     = p;
        apdata = '{id: 5'($urandom), error: 1'($urandom), data: {$urandom, $urandom}};
        apv    = 1'b0;
        if (ap && q.size() > 0) begin
            apv    = 1'b1;
            apdata = q[0].resp;
        end
    endtask

    // Check all outputs against the reference, then advance one clock.
    task automatic run_cycle();
        int           w;
        logic         can;
        logic         e_aqv;
        logic         e_apr;
        logic [N-1:0] e_qr;
        logic [N-1:0] e_pv;
        acc_resp_t    e_pd;
        #1;
        w     = model_winner(qv);
        can   = (q.size() < MAX);
        e_aqv = (qv != '0) && can;
        e_qr  = '0;
        if (w >= 0 && aqr && can) e_qr[w] = 1'b1;
        e_pv  = '0;
        e_apr = 1'b0;
        e_pd  = '0;
        if (q.size() > 0) begin
            if (apv) e_pv[q[0].core] = 1'b1;
            e_apr = pr[q[0].core];
            e_pd  = apdata;
        end
        chk("acc_qvalid", aqv, e_aqv);
        chk("core_qready", qready, e_qr);
        if (w >= 0) chk("acc_qdata", aqd, qdata[w]);
        chk("core_pvalid", pvalid, e_pv);
        chk("acc_pready", apr, e_apr);
        chk("core_pdata", pdata, e_pd);
        chk("contention", ccnt, exp_contention());
        hs_seen = ((qready & qv) != '0) ? 1 : 0;
        @(posedge clk);
        if (e_aqv && aqr) begin
            q.push_back('{core: w, resp: '{id: qdata[w].id, error: 1'b0, data: qdata[w].data_arga}});
            rr = (w + 1) % N;
        end
        if (apv && e_apr) void'(q.pop_front());
`ifdef SHARED_ACC_CONTENTION_CNT_EN
        if ($countones(qv) >= 2 && cnt_model != 32'hFFFF_FFFF) cnt_model++;
`endif
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_qready"}, qready, '0);
        chk({tag, "_pvalid"}, pvalid, '0);
        chk({tag, "_aqvalid"}, aqv, 1'b0);
        chk({tag, "_apready"}, apr, 1'b0);
        chk({tag, "_pdata"}, pdata, '0);
        chk({tag, "_contention"}, ccnt, '0);
    endtask

    task automatic model_clear();
        q.delete();
        rr        = 0;
        cnt_model = '0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        qv  = '1;
        aqr = 1'b1;
        apv = 1'b0;
        pr  = '1;
        #2;
        chk_reset(tag);
        @(negedge clk);
        rst = 1'b0;
        qv  = '0;
        aqr = 1'b0;
        model_clear();
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < N; c++) qdata[c] = rand_req();
        apdata = '0;
        do_reset("por");

        // Single requester, response one cycle later.
        drive(4'b0100, 1'b1, 1'b0, 4'b1111);
        qdata[2].data_arga = 64'h1234;
        run_cycle();
        drive(4'b0000, 1'b1, 1'b1, 4'b1111);
        #1;
        chk("t1_pvalid", pvalid, 4'b0100);
        chk("t1_pdata", pdata.data, 64'h1234);
        run_cycle();

        // All cores valid from pointer 0: grant order 0,1,2,3,0.
        do_reset("t2_rst");
        for (int k = 0; k < 5; k++) begin
            drive(4'b1111, 1'b1, 1'b1, 4'b1111);
            #1;
            chk("t2_grant", qready, 4'b0001 << order[k]);
            run_cycle();
        end
        for (int k = 0; k < 8; k++) begin
            drive(4'b0000, 1'b0, 1'b1, 4'b1111);
            run_cycle();
        end

        // No responses: exactly MAX grants, then blocked until a pop.
        do_reset("t3_rst");
        hs_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            drive(4'b1111, 1'b1, 1'b0, 4'b1111);
            run_cycle();
            hs_cnt += hs_seen;
        end
        chk("t3_hs_count", hs_cnt, 4);
        drive(4'b1111, 1'b1, 1'b1, 4'b1111);
        #1;
        chk("t3_full_pop_noready", qready, 4'b0000);
        run_cycle();
        drive(4'b1111, 1'b1, 1'b0, 4'b1111);
        #1;
        chk("t3_regrant", qready, 4'b0001);
        run_cycle();

        // Head core 1 back-pressures the response for 3 cycles.
        do_reset("t4_rst");
        drive(4'b0010, 1'b1, 1'b0, 4'b1111);
        run_cycle();
        for (int k = 0; k < 3; k++) begin
            drive(4'b0000, 1'b1, 1'b1, 4'b1101);
            #1;
            chk("t4_hold_pready", apr, 1'b0);
            chk("t4_hold_pvalid", pvalid, 4'b0010);
            chk("t4_hold_pdata", pdata, q[0].resp);
            run_cycle();
        end
        drive(4'b0000, 1'b1, 1'b1, 4'b1111);
        #1;
        chk("t4_release_pready", apr, 1'b1);
        run_cycle();

        // Asynchronous reset with 3 outstanding.
        do_reset("t5_pre");
        for (int k = 0; k < 3; k++) begin
            drive(4'b1111, 1'b1, 1'b0, 4'b1111);
            run_cycle();
        end
        drive(4'b1111, 1'b1, 1'b1, 4'b1111);
        #2;
        rst = 1'b1;
        #1;
        chk_reset("t5_async");
        @(negedge clk);
        qv  = '0;
        apv = 1'b0;
        model_clear();
        rst = 1'b0;
        drive(4'b1111, 1'b1, 1'b0, 4'b1111);
        #1;
        chk("t5_rr_restart", qready, 4'b0001);
        run_cycle();

        // Contention: 10 cycles with two requesters, 5 with one.
        do_reset("t6_rst");
        for (int k = 0; k < 10; k++) begin
            drive(4'b1001, 1'b0, 1'b0, 4'b1111);
            run_cycle();
        end
        for (int k = 0; k < 5; k++) begin
            drive(4'b0001, 1'b0, 1'b0, 4'b1111);
            run_cycle();
        end
        #1;
`ifdef SHARED_ACC_CONTENTION_CNT_EN
        chk("t6_contention_total", ccnt, 32'd10);
`else
        chk("t6_contention_total", ccnt, 32'd0);
`endif

        // Randomised traffic against the reference.
        do_reset("t7_rst");
        for (int k = 0; k < 300; k++) begin
            drive(N'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), N'($urandom));
            run_cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
